// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard for an in-order issue stage.
// Each architectural register has a countdown of cycles until its pending result is
// forwardable. The issue check stalls on RAW (source still too far out) and WAW
// (an older write would land after the new one).
module hazard_scoreboard #(
  parameter int unsigned REG_NUM = 32,
  parameter int unsigned LAT_W   = 3,
  parameter int unsigned FWD_THR = 1,
  parameter int unsigned ADDR_W  = $clog2(REG_NUM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [4:0]        op_code,
  input  logic [4:0]        funct,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  input  logic              rd_write,
  input  logic [LAT_W-1:0]  wb_lat,
  input  logic              flush,
  output logic              r1_used,
  output logic              r2_used,
  output logic              stall,
  output logic              busy_any
);

  logic [LAT_W-1:0] cnt_q [REG_NUM];
  logic [LAT_W-1:0] cnt_d [REG_NUM];

  logic              alu_funct_ok;
  logic [ADDR_W-1:0] rs1_e, rs2_e, rd_e;
  logic              raw1, raw2, waw, accept, load;

  // Register numbers beyond the file alias to x0, which never carries a hazard.
  function automatic logic [ADDR_W-1:0] eff_addr(input logic [ADDR_W-1:0] a);
    return (32'(a) < REG_NUM) ? a : '0;
  endfunction

  assign rs1_e = eff_addr(rs1);
  assign rs2_e = eff_addr(rs2);
  assign rd_e  = eff_addr(rd);

  // Recognised register-register ALU encodings ({inst[30], inst[25], funct3}).
  always_comb begin
    alu_funct_ok = 1'b0;
    case (funct)
      5'b00000, 5'b10000, 5'b00111, 5'b00110, 5'b00010,
      5'b00011, 5'b00101, 5'b00001, 5'b00100, 5'b10101: alu_funct_ok = 1'b1;
      default: alu_funct_ok = 1'b0;
    endcase
  end

  // Source-operand use decode from the major opcode.
  always_comb begin
    r1_used = 1'b0;
    r2_used = 1'b0;
    case (op_code)
      5'h00, 5'h04, 5'h19: r1_used = 1'b1;
      5'h08, 5'h18: begin
        r1_used = 1'b1;
        r2_used = 1'b1;
      end
      5'h0C: begin
        r1_used = alu_funct_ok;
        r2_used = alu_funct_ok;
      end
      5'h1C: begin
        r1_used = 1'b1;
        r2_used = (funct == 5'b00000);
      end
      default: begin
        r1_used = 1'b0;
        r2_used = 1'b0;
      end
    endcase
  end

  // Hazard check against the registered (pre-decrement) counters.
  always_comb begin
    raw1   = r1_used && (rs1_e != '0) && (32'(cnt_q[rs1_e]) > FWD_THR);
    raw2   = r2_used && (rs2_e != '0) && (32'(cnt_q[rs2_e]) > FWD_THR);
    waw    = rd_write && (rd_e != '0) && (cnt_q[rd_e] > wb_lat);
    stall  = issue_valid && !flush && (raw1 || raw2 || waw);
    accept = issue_valid && !stall && !flush;
    load   = accept && rd_write && (rd_e != '0) && (wb_lat != '0);
  end

  // Next counter values: saturating decrement, issue load overrides, flush clears all.
  always_comb begin
    for (int r = 0; r < int'(REG_NUM); r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : '0;
    end
    cnt_d[0] = '0;
    if (load) begin
      cnt_d[rd_e] = wb_lat;
    end
    if (flush) begin
      for (int r = 0; r < int'(REG_NUM); r++) begin
        cnt_d[r] = '0;
      end
    end
  end

  // Counter state; reset wins over flush and issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < int'(REG_NUM); r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Any pending write in flight.
  always_comb begin
    busy_any = 1'b0;
    for (int r = 0; r < int'(REG_NUM); r++) begin
      busy_any = busy_any | (cnt_q[r] != '0);
    end
  end

endmodule
